core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter ADDRESS_BITS, default 16, width of the PC in the surrounding core; carried for consistency, no ports depend on it.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, the number of wait cycles allowed for a memory response before error (legal range 1..255).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: begin instruction execution from IDLE.
REQ-006 SHALL have port halt_req, input, 1: stop after the current instruction retires.
REQ-007 SHALL have port dec_wEn, input, 1: register-write enable from the decoder.
REQ-008 SHALL have port dec_mem_wEn, input, 1: store indication from the decoder.
REQ-009 SHALL have port dec_wb_sel, input, 1: load indication from the decoder.
REQ-010 SHALL have port imem_ready, input, 1: instruction memory response valid.
REQ-011 SHALL have port dmem_ready, input, 1: data memory response or acknowledge.
REQ-012 SHALL have port imem_req, output, 1: instruction fetch request.
REQ-013 SHALL have port ir_wEn, output, 1: latch the instruction register.
REQ-014 SHALL have port dmem_req, output, 1: data memory request.
REQ-015 SHALL have port dmem_wEn, output, 1: data memory write strobe.
REQ-016 SHALL have port rf_wEn, output, 1: gated register-file write enable.
REQ-017 SHALL have port pc_wEn, output, 1: commit next PC.
REQ-018 SHALL have port busy, output, 1: high in every state except IDLE and ERROR.
REQ-019 SHALL have port mem_err, output, 1: sticky timeout flag.
REQ-020 SHALL have port state, output, 3 bits: current state encoding.

Function
REQ-021 SHALL use state encodings IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, ERROR=6; code 7 SHALL return to IDLE on the next clock.
REQ-022 SHALL move IDLE->FETCH when start=1 and ignore start in all other states.
REQ-023 SHALL drive imem_req=1 throughout FETCH and move to DECODE on the first cycle with imem_ready=1.
REQ-024 SHALL drive ir_wEn as imem_ready AND (state==FETCH), combinationally, so it pulses exactly one cycle per fetch.
REQ-025 SHALL make DECODE last exactly one cycle, then go to EXECUTE.
REQ-026 SHALL make EXECUTE last exactly one cycle, going to MEMORY if dec_wb_sel or dec_mem_wEn is 1, else to WRITEBACK.
REQ-027 SHALL, in MEMORY, drive dmem_req=1 and dmem_wEn=dec_mem_wEn, and move to WRITEBACK on dmem_ready=1.
REQ-028 SHALL make WRITEBACK last exactly one cycle with pc_wEn=1 and rf_wEn=dec_wEn, going to IDLE if halt_req=1, else to FETCH.
REQ-029 SHALL hold rf_wEn, pc_wEn, dmem_req and dmem_wEn at 0 in all states other than those named above.
REQ-030 SHALL use an 8-bit wait counter that clears on entry to FETCH or MEMORY and increments each cycle spent there without ready.
REQ-031 SHALL, when the wait counter reaches MEM_TIMEOUT with ready=0, enter ERROR and set mem_err=1; if ready arrives on that same cycle, ready SHALL win.
REQ-032 SHALL make ERROR absorbing: all request and enable outputs 0; exit only via reset.
REQ-033 SHALL give a best-case latency of 4 cycles per non-memory instruction and 5 per load or store (ready on first cycle).

Reset
REQ-034 SHALL, while reset=0, immediately force state=IDLE, wait counter=0 and mem_err=0, with all outputs at 0.
REQ-035 SHALL abandon any in-flight request when reset is asserted mid-instruction, with no further ir_wEn, rf_wEn or pc_wEn pulse.

Configuration
REQ-036 SHALL, when SEQ_PERF_CNT_EN is defined, add output instret [31:0], which resets to 0, increments in each WRITEBACK cycle and wraps from 0xFFFFFFFF to 0.
REQ-037 SHALL, when SEQ_PERF_CNT_EN is undefined, have no instret port and no counter logic.

Verification
REQ-038 SHALL test: start pulse, ADD (dec_wEn=1), readies always high -> states 1,2,3,5 then FETCH; rf_wEn=1 and pc_wEn=1 for one cycle each.
REQ-039 SHALL test: store (dec_mem_wEn=1) with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_wEn=1 throughout, rf_wEn stays 0.
REQ-040 SHALL test: MEM_TIMEOUT=15 with imem_ready held 0 -> ERROR after 15 FETCH wait cycles, mem_err=1, busy=0, start ignored.
REQ-041 SHALL test: imem_ready arriving on the exact timeout cycle -> DECODE, mem_err=0.
REQ-042 SHALL test: halt_req=1 during WRITEBACK -> IDLE next cycle; reset pulled low in MEMORY -> IDLE immediately with dmem_req=0.
REQ-043 SHALL test, with SEQ_PERF_CNT_EN defined: 3 retired instructions -> instret=3; instret forced to 0xFFFFFFFF and one more retired -> instret=0.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with memory timeout.
// Optional retired-instruction counter (instret) enabled by defining SEQ_PERF_CNT_EN.
module core_sequencer #(
  parameter int ADDRESS_BITS = 16,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       halt_req,
  input  logic       dec_wEn,
  input  logic       dec_mem_wEn,
  input  logic       dec_wb_sel,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_wEn,
  output logic       dmem_req,
  output logic       dmem_wEn,
  output logic       rf_wEn,
  output logic       pc_wEn,
  output logic       busy,
  output logic       mem_err,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0] instret,
`endif
  output logic [2:0] state
);

  // Handshake: a request (imem_req/dmem_req) stays high every cycle of its state;
  // the cycle on which the matching ready is high completes the transfer.

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || ADDRESS_BITS < 1) begin : g_bad_cfg
    $error("core_sequencer: illegal MEM_TIMEOUT or ADDRESS_BITS");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_ERROR     = 3'd6,
    S_ILLEGAL   = 3'd7
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       timeout_hit;
  logic       waiting;

  assign state       = state_q;
  assign timeout_hit = (wait_cnt == TIMEOUT);

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_wEn = 1'b0;
    rf_wEn   = 1'b0;
    pc_wEn   = 1'b0;
    case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        // A ready on the timeout cycle still completes the fetch.
        if (imem_ready)       state_d = S_DECODE;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = (dec_wb_sel || dec_mem_wEn) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_wEn = dec_mem_wEn;
        if (dmem_ready)       state_d = S_WRITEBACK;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_WRITEBACK: begin
        pc_wEn  = 1'b1;
        rf_wEn  = dec_wEn;
        state_d = halt_req ? S_IDLE : S_FETCH;
      end
      S_ERROR:     state_d = S_ERROR;
      default:     state_d = S_IDLE;
    endcase
  end

  assign ir_wEn  = imem_ready && (state_q == S_FETCH);
  assign busy    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                   (state_q == S_MEMORY) || (state_q == S_WRITEBACK);

  // Counter runs only while parked in a memory-wait state; any entry or exit clears it.
  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMORY)) && (state_d == state_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= waiting ? wait_cnt + 8'd1 : 8'd0;
      if (state_d == S_ERROR) mem_err <= 1'b1;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                       instret <= 32'd0;
    else if (state_q == S_WRITEBACK)  instret <= instret + 32'd1;
  end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: a timeline model turns instruction descriptors into per-cycle
// stimulus and expected outputs, which a driver replays and checks every cycle.
module tb_core_sequencer;
  localparam int TO = 15;
  localparam int OW = 11;
  localparam int W  = 18;
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
                         MEMORY = 3'd4, WB = 3'd5, ERROR = 3'd6;

  logic clock, reset, start, halt_req, dec_wEn, dec_mem_wEn, dec_wb_sel, imem_ready, dmem_ready;
  logic imem_req, ir_wEn, dmem_req, dmem_wEn, rf_wEn, pc_wEn, busy, mem_err;
  logic [2:0] state;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [31:0]  ret_q[$];
  bit           model_err;
  logic [31:0]  model_ret;

  core_sequencer #(.ADDRESS_BITS(16), .MEM_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
    .dec_wEn(dec_wEn), .dec_mem_wEn(dec_mem_wEn), .dec_wb_sel(dec_wb_sel),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_wEn(ir_wEn), .dmem_req(dmem_req), .dmem_wEn(dmem_wEn),
    .rf_wEn(rf_wEn), .pc_wEn(pc_wEn), .busy(busy), .mem_err(mem_err),
`ifdef SEQ_PERF_CNT_EN
    .instret(instret),
`endif
    .state(state)
  );

`ifndef SEQ_PERF_CNT_EN
  assign instret = 32'd0;
`endif

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic logic [OW-1:0] observed();
    return {state, busy, mem_err, imem_req, ir_wEn, dmem_req, dmem_wEn, rf_wEn, pc_wEn};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs for one cycle, straight from the per-state output rules.
  function automatic logic [OW-1:0] outs(input logic [2:0] st, input bit ir, input bit decw,
                                         input bit decm, input bit err);
    bit bz;
    bz = (st >= FETCH) && (st <= WB);
    return {st, bz, err, st == FETCH, (st == FETCH) && ir, st == MEMORY,
            (st == MEMORY) && decm, (st == WB) && decw, st == WB};
  endfunction

  task automatic push(input logic [2:0] st, input bit s, input bit h, input bit ir, input bit dr,
                      input bit decw, input bit decm, input bit decl);
    exp_q.push_back({s, h, ir, dr, decw, decm, decl, outs(st, ir, decw, decm, model_err)});
    ret_q.push_back(model_ret);
    if (st == WB) model_ret = model_ret + 32'd1;
  endtask

  // idle_n IDLE cycles without start, then the start cycle.
  task automatic gen_start(input int idle_n);
    for (int i = 0; i < idle_n; i++) push(IDLE, 1'b0, rb(), rb(), rb(), rb(), rb(), rb());
    push(IDLE, 1'b1, rb(), rb(), rb(), rb(), rb(), rb());
  endtask

  task automatic gen_error();
    model_err = 1'b1;
    for (int i = 0; i < 3; i++) push(ERROR, 1'b1, rb(), rb(), rb(), rb(), rb(), rb());
  endtask

  // df/dm = ready-less wait cycles before ready; a value above TO means ready never comes.
  task automatic gen_instr(input int df, input int dm, input bit decw, input bit decm,
                           input bit decl, input bit halt);
    int nf, nm;
    nf = (df > TO) ? TO + 1 : df;
    for (int i = 0; i < nf; i++) push(FETCH, rb(), rb(), 1'b0, rb(), decw, decm, decl);
    if (df > TO) begin
      gen_error();
      return;
    end
    push(FETCH, rb(), rb(), 1'b1, rb(), decw, decm, decl);
    push(DECODE, rb(), rb(), rb(), rb(), decw, decm, decl);
    push(EXECUTE, rb(), rb(), rb(), rb(), decw, decm, decl);
    if (decm || decl) begin
      nm = (dm > TO) ? TO + 1 : dm;
      for (int i = 0; i < nm; i++) push(MEMORY, rb(), rb(), rb(), 1'b0, decw, decm, decl);
      if (dm > TO) begin
        gen_error();
        return;
      end
      push(MEMORY, rb(), rb(), rb(), 1'b1, decw, decm, decl);
    end
    push(WB, rb(), halt, rb(), rb(), decw, decm, decl);
  endtask

  // driver: replay every queued cycle and compare
  task automatic run_queue();
    logic [W-1:0] e;
    logic [31:0]  r;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = ret_q.pop_front();
      @(negedge clock);
      {start, halt_req, imem_ready, dmem_ready, dec_wEn, dec_mem_wEn, dec_wb_sel} = e[W-1:OW];
      #1;
      cyc++;
      check("outputs", 32'(observed()), 32'(e[OW-1:0]));
`ifdef SEQ_PERF_CNT_EN
      check("instret", instret, r);
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    {start, imem_ready, dmem_ready, dec_wEn} = 4'hF;
    #1;
    check("reset_now", 32'(observed()), 32'd0);
    @(negedge clock);
    #1;
    check("reset_hold", 32'(observed()), 32'd0);
`ifdef SEQ_PERF_CNT_EN
    check("reset_instret", instret, 32'd0);
`endif
    {start, halt_req, imem_ready, dmem_ready, dec_wEn, dec_mem_wEn, dec_wb_sel} = 7'd0;
    reset = 1'b1;
    model_err = 1'b0;
    model_ret = 32'd0;
  endtask

  initial begin
    int df, dm, kind;
    bit hlt;
    reset = 1'b0;
    {start, halt_req, imem_ready, dmem_ready, dec_wEn, dec_mem_wEn, dec_wb_sel} = 7'd0;
    model_err = 1'b0;
    model_ret = 32'd0;
    #1;
    check("reset_t0", 32'(observed()), 32'd0);
    do_reset();

    // ADD with readies immediate, then a store with dmem ready after 3 waits, then halt
    gen_start(1);
    gen_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    gen_instr(0, 3, 1'b0, 1'b1, 1'b0, 1'b0);
    gen_instr(1, 2, 1'b1, 1'b0, 1'b1, 1'b1);
    push(IDLE, 1'b0, rb(), rb(), rb(), rb(), rb(), rb());
    run_queue();

    // ready exactly on the timeout cycle, fetch and memory
    gen_start(0);
    gen_instr(TO, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    gen_instr(0, TO, 1'b1, 1'b0, 1'b1, 1'b1);
    push(IDLE, 1'b0, rb(), rb(), rb(), rb(), rb(), rb());
    run_queue();

    // fetch timeout -> ERROR, start ignored, leave by reset
    gen_start(0);
    gen_instr(TO + 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_queue();
    do_reset();

    // memory timeout on a store
    gen_start(0);
    gen_instr(0, TO + 1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_queue();
    do_reset();

    // reset pulled mid-MEMORY
    gen_start(0);
    push(FETCH, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    push(DECODE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    push(EXECUTE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    push(MEMORY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    push(MEMORY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    run_queue();
    do_reset();

    // randomized instruction stream
    gen_start($urandom_range(0, 2));
    for (int k = 0; k < 25; k++) begin
      df   = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
      dm   = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, 3);
      kind = $urandom_range(0, 2);
      hlt  = (k == 24) || ($urandom_range(0, 4) == 0);
      gen_instr(df, dm, rb(), kind == 2, kind == 1, hlt);
      if (hlt && k != 24) gen_start($urandom_range(0, 2));
    end
    push(IDLE, 1'b0, rb(), rb(), rb(), rb(), rb(), rb());
    run_queue();

`ifdef SEQ_PERF_CNT_EN
    do_reset();
    gen_start(0);
    gen_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    gen_instr(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
    gen_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    push(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_queue();
    check("instret_three", instret, 32'd3);
    @(negedge clock);
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    model_ret = 32'hFFFF_FFFF;
    gen_start(0);
    gen_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    push(IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_queue();
    check("instret_wrap", instret, 32'd0);
`endif

    // report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
